// File: rtl/tcp_rt_timer_sched.sv
// Per-flow TCP retransmit timers with a round-robin expiry scan toward the TX engine.
// Optional exponential timeout backoff per flow when RT_BACKOFF_EN is defined.
module tcp_rt_timer_sched #(
    parameter int NUM_FLOWS      = 8,
    parameter int FLOWID_W       = $clog2(NUM_FLOWS),
    parameter int TS_W           = 64,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BACKOFF_W      = 3,
    parameter int MAX_BACKOFF    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm_val,
    input  logic [FLOWID_W-1:0]  arm_flowid,
    input  logic                 disarm_val,
    input  logic [FLOWID_W-1:0]  disarm_flowid,
    output logic [TS_W-1:0]      now_ts,
    output logic                 rt_req_val,
    output logic [FLOWID_W-1:0]  rt_req_flowid,
    output logic [BACKOFF_W-1:0] rt_req_backoff,
    input  logic                 rt_req_rdy
);

    typedef struct packed {
        logic [TS_W-1:0] timestamp;
        logic            timer_armed;
    } tx_ack_timer_struct;

    localparam logic [BACKOFF_W-1:0] BO_MAX = BACKOFF_W'(MAX_BACKOFF);

    tx_ack_timer_struct  timers_q [NUM_FLOWS];
    tx_ack_timer_struct  cur;
    logic [TS_W-1:0]     now_q;
    logic [FLOWID_W-1:0] ptr_q;
    logic                pend_dirty_q;
    logic                hs;
    logic                idle;
    logic                hit;
    logic                pend_touch;
    logic [TS_W-1:0]     age;
    logic [TS_W-1:0]     limit;
    logic [BACKOFF_W-1:0] bo_val;
    logic [BACKOFF_W-1:0] cur_bo;

    assign now_ts = now_q;
    assign hs     = rt_req_val && rt_req_rdy;
    assign idle   = !rt_req_val || rt_req_rdy;
    assign cur    = timers_q[ptr_q];
    assign age    = now_q - cur.timestamp;
    assign cur_bo = (bo_val > BO_MAX) ? BO_MAX : bo_val;

`ifdef RT_BACKOFF_EN
    logic [BACKOFF_W-1:0] bo_q [NUM_FLOWS];

    assign bo_val = bo_q[ptr_q];
    assign limit  = TS_W'(TIMEOUT_CYCLES) << bo_q[ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) bo_q[i] <= '0;
        end else begin
            if (hs && bo_q[rt_req_flowid] < BO_MAX)
                bo_q[rt_req_flowid] <= bo_q[rt_req_flowid] + BACKOFF_W'(1);
            if (disarm_val)
                bo_q[disarm_flowid] <= '0;
        end
    end
`else
    assign bo_val = '0;
    assign limit  = TS_W'(TIMEOUT_CYCLES);
`endif

    // A flow touched by arm/disarm/handshake this cycle must not fire on stale state
    always_comb begin
        hit = cur.timer_armed && (age >= limit);
        if (arm_val && arm_flowid == ptr_q)       hit = 1'b0;
        if (disarm_val && disarm_flowid == ptr_q) hit = 1'b0;
        if (hs && rt_req_flowid == ptr_q)         hit = 1'b0;
    end

    assign pend_touch = (arm_val && arm_flowid == rt_req_flowid) ||
                        (disarm_val && disarm_flowid == rt_req_flowid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) timers_q[i] <= '0;
        end else begin
            if (disarm_val)
                timers_q[disarm_flowid].timer_armed <= 1'b0;
            if (hs && !pend_dirty_q)
                timers_q[rt_req_flowid].timer_armed <= 1'b0;
            if (arm_val)
                timers_q[arm_flowid] <= '{timestamp: now_q, timer_armed: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q          <= '0;
            ptr_q          <= '0;
            rt_req_val     <= 1'b0;
            rt_req_flowid  <= '0;
            rt_req_backoff <= '0;
            pend_dirty_q   <= 1'b0;
        end else begin
            now_q <= now_q + TS_W'(1);
            if (idle) begin
                ptr_q      <= ptr_q + FLOWID_W'(1);
                rt_req_val <= hit;
                if (hit) begin
                    rt_req_flowid  <= ptr_q;
                    rt_req_backoff <= cur_bo;
                end
            end
            if (hs)
                pend_dirty_q <= 1'b0;
            else if (rt_req_val && pend_touch)
                pend_dirty_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tcp_rt_timer_sched.sv
// Scoreboard bench for tcp_rt_timer_sched (NUM_FLOWS=4, TIMEOUT_CYCLES=20).
// Second small-time-base instance exercises timestamp wrap.
module tb_tcp_rt_timer_sched;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TO = 20;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm_val = 1'b0;
    logic [FW-1:0] arm_flowid = '0;
    logic          disarm_val = 1'b0;
    logic [FW-1:0] disarm_flowid = '0;
    logic [63:0]   now_ts;
    logic          rt_req_val;
    logic [FW-1:0] rt_req_flowid;
    logic [BW-1:0] rt_req_backoff;
    logic          rt_req_rdy = 1'b1;

    logic          w_arm_val = 1'b0;
    logic [FW-1:0] w_arm_flowid = '0;
    logic          w_disarm_val = 1'b0;
    logic [FW-1:0] w_disarm_flowid = '0;
    logic [4:0]    w_now_ts;
    logic          w_val;
    logic [FW-1:0] w_fid;
    logic [BW-1:0] w_bo;
    logic          w_rdy = 1'b1;

    tcp_rt_timer_sched #(
        .NUM_FLOWS(NF), .TS_W(64), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arm_val(arm_val), .arm_flowid(arm_flowid),
        .disarm_val(disarm_val), .disarm_flowid(disarm_flowid),
        .now_ts(now_ts),
        .rt_req_val(rt_req_val), .rt_req_flowid(rt_req_flowid),
        .rt_req_backoff(rt_req_backoff), .rt_req_rdy(rt_req_rdy)
    );

    tcp_rt_timer_sched #(
        .NUM_FLOWS(NF), .TS_W(5), .TIMEOUT_CYCLES(TO)
    ) dut_w (
        .clk(clk), .rst_n(rst_n),
        .arm_val(w_arm_val), .arm_flowid(w_arm_flowid),
        .disarm_val(w_disarm_val), .disarm_flowid(w_disarm_flowid),
        .now_ts(w_now_ts),
        .rt_req_val(w_val), .rt_req_flowid(w_fid),
        .rt_req_backoff(w_bo), .rt_req_rdy(w_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     f;
        longint t;
        int     slack;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    longint        cyc;
    int            bo_m[NF];
    logic          held_v = 1'b0;
    logic [FW-1:0] held_f;
    logic [BW-1:0] held_b;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic take_req();
        int     idx;
        longint lim;
        longint lo;
        longint hi;
        exp_t   e;
        idx = -1;
        foreach (sb[i])
            if (idx < 0 && sb[i].f == int'(rt_req_flowid)) idx = i;
        if (idx < 0) begin
            chk("unexp_fid", 64'(rt_req_flowid), 64'(NF));
        end else begin
            e = sb[idx];
            sb.delete(idx);
`ifdef RT_BACKOFF_EN
            lim = longint'(TO) << bo_m[e.f];
`else
            lim = longint'(TO);
`endif
            lo = e.t + lim + 1;
            hi = e.t + lim + NF + 1 + e.slack;
            chk("req_bo", 64'(rt_req_backoff), 64'(bo_m[e.f]));
            chk("lat_lo", 64'(cyc >= lo), 64'd1);
            chk("lat_hi", 64'(cyc <= hi), 64'd1);
`ifdef RT_BACKOFF_EN
            if (bo_m[e.f] < 6) bo_m[e.f]++;
`endif
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            chk("now_ts", now_ts, 64'(cyc));
            if (held_v) begin
                chk("hold_val", 64'(rt_req_val), 64'd1);
                chk("hold_fid", 64'(rt_req_flowid), 64'(held_f));
                chk("hold_bo", 64'(rt_req_backoff), 64'(held_b));
            end
            held_v = 1'b0;
            if (rt_req_val) begin
                if (rt_req_rdy) begin
                    take_req();
                end else begin
                    held_v = 1'b1;
                    held_f = rt_req_flowid;
                    held_b = rt_req_backoff;
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(bit av, int af, bit dv, int df, bit push, int slack);
        arm_val       = av;
        arm_flowid    = FW'(af);
        disarm_val    = dv;
        disarm_flowid = FW'(df);
        if (push) sb.push_back('{af, cyc, slack});
`ifdef RT_BACKOFF_EN
        if (dv) bo_m[df] = 0;
`endif
        tick();
        arm_val    = 1'b0;
        disarm_val = 1'b0;
    endtask

    task automatic wait_val(int bound, string tag);
        for (int i = 0; i < bound && !rt_req_val; i++) tick();
        chk(tag, 64'(rt_req_val), 64'd1);
    endtask

    task automatic wait_sb(int bound, string tag);
        for (int i = 0; i < bound && sb.size() != 0; i++) tick();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        longint t0;
        longint first;
        int     cnt;
        foreach (bo_m[i]) bo_m[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_now", now_ts, 64'd0);
        chk("rst_val", 64'(rt_req_val), 64'd0);
        chk("rst_fid", 64'(rt_req_flowid), 64'd0);
        chk("rst_bo", 64'(rt_req_backoff), 64'd0);
        chk("rst_wval", 64'(w_val), 64'd0);
        rst_n = 1'b1;

        // single flow fires once, then stays disarmed
        while (cyc < 5) tick();
        drive(1, 2, 0, 0, 1, 0);
        wait_sb(200, "t1_done");
        tick(60);

        // disarm cancels; same-cycle arm+disarm arms; distinct flows both apply
        drive(1, 1, 0, 0, 0, 0);
        tick(4);
        drive(0, 0, 1, 1, 0, 0);
        tick(60);
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1, 0);
        drive(1, 0, 1, 3, 1, 0);
        wait_sb(300, "t2_done");
        tick(60);

        // stalled output holds payload
        rt_req_rdy = 1'b0;
        drive(1, 0, 0, 0, 1, 400);
        drive(1, 3, 0, 0, 1, 400);
        tick(60);
        rt_req_rdy = 1'b1;
        wait_sb(400, "t3_done");
        tick(40);

        // re-arm of pending flow keeps it armed
        rt_req_rdy = 1'b0;
        drive(1, 1, 0, 0, 1, 500);
        wait_val(400, "t4_pend");
        drive(1, 1, 0, 0, 1, 0);
        tick(3);
        rt_req_rdy = 1'b1;
        wait_sb(500, "t4_done");
        tick(40);

        // timestamp wrap on a 5-bit time base
        while ((cyc % 32) != 28) tick();
        chk("wrap_now", 64'(w_now_ts), 64'(cyc % 32));
        w_arm_val = 1'b1;
        t0 = cyc;
        tick();
        w_arm_val = 1'b0;
        first = -1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_val) begin
                cnt++;
                if (first < 0) begin
                    first = cyc;
                    chk("wrap_fid", 64'(w_fid), 64'd0);
                end
            end
        end
        chk("wrap_lo", 64'(first >= t0 + TO + 1), 64'd1);
        chk("wrap_hi", 64'(first >= 0 && first <= t0 + TO + NF + 1), 64'd1);
        chk("wrap_cnt", 64'(cnt), 64'd1);
        tick();

        // repeated re-arm of one flow, then disarm resets backoff
        drive(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 1, 0);
            wait_sb(300, "t6_fire");
        end
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        wait_sb(300, "t6_bo_clr");
        tick(20);

        // reset while a request is pending
        rt_req_rdy = 1'b0;
        drive(1, 2, 0, 0, 1, 500);
        wait_val(400, "rst_pend");
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 64'(rt_req_val), 64'd0);
        chk("mid_rst_now", now_ts, 64'd0);
        sb.delete();
        foreach (bo_m[i]) bo_m[i] = 0;
        tick(2);
        rst_n = 1'b1;
        rt_req_rdy = 1'b1;
        tick(100);
        drive(1, 2, 0, 0, 1, 0);
        wait_sb(100, "post_rst");
        tick(40);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
